// File: rtl/apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge
// Purpose  : Single-master APB bridge. Turns a level-sampled transfer request
//            plus direction into an APB SETUP/ACCESS sequence toward one
//            slave. Address and write data come from internal counters.
//            Captured read data is returned on a side port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   pclk        in   APB clock, all state changes on the rising edge
//   preset_n    in   asynchronous reset, ACTIVE-HIGH despite the name
//   transfer    in   transfer request, sampled at posedge
//   rd_wr       in   direction, 1 = write, 0 = read
//   pready      in   slave ready
//   prdata      in   slave read data
//   pselect     out  APB PSEL
//   penable     out  APB PENABLE
//   pwrite      out  APB PWRITE
//   pwdata      out  APB PWDATA (write-data counter)
//   paddr       out  APB PADDR (address counter)
//   rdata       out  data of the last completed read
//   rdata_valid out  one-cycle pulse when rdata updates
// ============================================================================
module apb_bridge #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [WIDTH-1:0] ADDR_STEP  = WIDTH'(1),
  parameter logic [WIDTH-1:0] WDATA_INIT = WIDTH'(16'h00A5)
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             transfer,
  input  logic             rd_wr,
  input  logic             pready,
  input  logic [WIDTH-1:0] prdata,
  output logic             pselect,
  output logic             penable,
  output logic             pwrite,
  output logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] paddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_complete;   // transfer finishes at this edge
  logic   w_load_dir;   // entering SETUP: capture rd_wr into pwrite

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    w_load_dir   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (transfer) begin
          w_next_state = ST_SETUP;
          w_load_dir   = 1'b1;
        end
      end
      ST_SETUP: begin
        w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Request inputs are only looked at when the current transfer ends,
        // so a new request can chain straight into SETUP without an IDLE gap.
        if (pready) begin
          w_complete = 1'b1;
          if (transfer) begin
            w_next_state = ST_SETUP;
            w_load_dir   = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. PSEL/PENABLE are decoded from the next
  // state so they line up with the state they describe.
  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      r_state     <= ST_IDLE;
      pselect     <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= WDATA_INIT;
      paddr       <= ADDR_BASE;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      pselect     <= (w_next_state != ST_IDLE);
      penable     <= (w_next_state == ST_ACCESS);
      rdata_valid <= 1'b0;

      if (w_load_dir) begin
        pwrite <= rd_wr;
      end

      // pwrite still reflects the finishing transfer here; a re-latch for a
      // back-to-back transfer only takes effect after this edge.
      if (w_complete) begin
        paddr <= paddr + ADDR_STEP;
        if (pwrite) begin
          pwdata <= pwdata + WIDTH'(1);
        end else begin
          rdata       <= prdata;
          rdata_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_bridge
// Purpose  : Self-checking bench for apb_bridge. A directed vector table
//            covers write, read, wait states and back-to-back transfers;
//            hand sequences cover asynchronous reset and counter wrap; a
//            randomized run is compared against a transfer-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_bridge;

  logic        clk;
  logic        rst;
  logic        transfer, rd_wr, pready;
  logic [15:0] prdata;
  logic        pselect, penable, pwrite, rdata_valid;
  logic [15:0] pwdata, paddr, rdata;

  // Second instance with counters starting at all-ones, for the wrap case
  logic        w_transfer, w_rd_wr;
  logic        w_pselect, w_penable, w_pwrite, w_rdata_valid;
  logic [15:0] w_pwdata, w_paddr, w_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_bridge u_dut (
    .pclk        (clk),
    .preset_n    (rst),
    .transfer    (transfer),
    .rd_wr       (rd_wr),
    .pready      (pready),
    .prdata      (prdata),
    .pselect     (pselect),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .paddr       (paddr),
    .rdata       (rdata),
    .rdata_valid (rdata_valid)
  );

  apb_bridge #(
    .ADDR_BASE  (16'hFFFF),
    .WDATA_INIT (16'hFFFF)
  ) u_wrap (
    .pclk        (clk),
    .preset_n    (rst),
    .transfer    (w_transfer),
    .rd_wr       (w_rd_wr),
    .pready      (w_penable),
    .prdata      (16'h0000),
    .pselect     (w_pselect),
    .penable     (w_penable),
    .pwrite      (w_pwrite),
    .pwdata      (w_pwdata),
    .paddr       (w_paddr),
    .rdata       (w_rdata),
    .rdata_valid (w_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        t, w, r;
    logic [15:0] pd;
    logic        psel, pen, pw;
    logic [15:0] addr, wd, rd;
    logic        rv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic t, input logic w, input logic r,
                              input logic [15:0] pd,
                              input logic psel, input logic pen, input logic pw,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic [15:0] rd, input logic rv);
    vec_t v;
    v.t = t; v.w = w; v.r = r; v.pd = pd;
    v.psel = psel; v.pen = pen; v.pw = pw;
    v.addr = addr; v.wd = wd; v.rd = rd; v.rv = rv;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic psel, input logic pen,
                           input logic pw, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input logic rv);
    check({tag, " pselect"},     {31'd0, pselect},     {31'd0, psel});
    check({tag, " penable"},     {31'd0, penable},     {31'd0, pen});
    check({tag, " pwrite"},      {31'd0, pwrite},      {31'd0, pw});
    check({tag, " paddr"},       {16'd0, paddr},       {16'd0, addr});
    check({tag, " pwdata"},      {16'd0, pwdata},      {16'd0, wd});
    check({tag, " rdata"},       {16'd0, rdata},       {16'd0, rd});
    check({tag, " rdata_valid"}, {31'd0, rdata_valid}, {31'd0, rv});
  endtask

  // Drive at the falling edge, let one rising edge pass, sample at the next
  // falling edge.
  task automatic cycle(input logic t, input logic w, input logic r,
                       input logic [15:0] pd);
    transfer = t; rd_wr = w; pready = r; prdata = pd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transfer-level reference model: tracks whether a transfer is in flight
  // and how many cycles it has been on the bus; counters are derived from
  // the number of completed reads/writes.
  bit          m_busy;
  int          m_age;
  bit          m_dir;
  logic [15:0] m_addr, m_wd, m_rd;
  bit          m_rv;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_dir = 0;
    m_addr = 16'h0000; m_wd = 16'h00A5; m_rd = 16'h0000; m_rv = 0;
  endtask

  task automatic model_edge(input logic t, input logic w, input logic r,
                            input logic [15:0] pd);
    m_rv = 0;
    if (!m_busy) begin
      if (t) begin
        m_busy = 1; m_age = 0; m_dir = w;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (r) begin
      m_addr = m_addr + 16'd1;
      if (m_dir) m_wd = m_wd + 16'd1;
      else begin
        m_rd = pd; m_rv = 1;
      end
      if (t) begin
        m_age = 0; m_dir = w;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_age = m_age + 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    transfer = 1'b0; rd_wr = 1'b0; pready = 1'b0; prdata = 16'h0000;
    w_transfer = 1'b0; w_rd_wr = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 16'h0000, 16'h00A5, 16'h0000, 0);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    //   t  w  rdy prdata     psel pen pw addr     pwdata   rdata    rv
    // write, single
    add(1, 1, 0, 16'h0000,  1, 0, 1, 16'h0000, 16'h00A5, 16'h0000, 0);
    add(0, 0, 1, 16'h0000,  1, 1, 1, 16'h0000, 16'h00A5, 16'h0000, 0);
    add(0, 0, 1, 16'h0000,  0, 0, 1, 16'h0001, 16'h00A6, 16'h0000, 0);
    add(0, 0, 1, 16'h1234,  0, 0, 1, 16'h0001, 16'h00A6, 16'h0000, 0);
    // read, single; rd_wr change during ACCESS ignored
    add(1, 0, 0, 16'h0000,  1, 0, 0, 16'h0001, 16'h00A6, 16'h0000, 0);
    add(0, 1, 0, 16'h0000,  1, 1, 0, 16'h0001, 16'h00A6, 16'h0000, 0);
    add(0, 0, 1, 16'h00EE,  0, 0, 0, 16'h0002, 16'h00A6, 16'h00EE, 1);
    add(0, 0, 0, 16'h0000,  0, 0, 0, 16'h0002, 16'h00A6, 16'h00EE, 0);
    // write with three wait states; request during wait ignored
    add(1, 1, 0, 16'h0000,  1, 0, 1, 16'h0002, 16'h00A6, 16'h00EE, 0);
    add(0, 0, 0, 16'h0000,  1, 1, 1, 16'h0002, 16'h00A6, 16'h00EE, 0);
    add(1, 0, 0, 16'h0000,  1, 1, 1, 16'h0002, 16'h00A6, 16'h00EE, 0);
    add(0, 0, 0, 16'h0000,  1, 1, 1, 16'h0002, 16'h00A6, 16'h00EE, 0);
    add(0, 0, 0, 16'h0000,  1, 1, 1, 16'h0002, 16'h00A6, 16'h00EE, 0);
    add(0, 0, 1, 16'h0000,  0, 0, 1, 16'h0003, 16'h00A7, 16'h00EE, 0);
    // back-to-back writes
    add(1, 1, 0, 16'h0000,  1, 0, 1, 16'h0003, 16'h00A7, 16'h00EE, 0);
    add(1, 1, 0, 16'h0000,  1, 1, 1, 16'h0003, 16'h00A7, 16'h00EE, 0);
    add(1, 1, 1, 16'h0000,  1, 0, 1, 16'h0004, 16'h00A8, 16'h00EE, 0);
    add(0, 0, 1, 16'h0000,  1, 1, 1, 16'h0004, 16'h00A8, 16'h00EE, 0);
    add(0, 0, 1, 16'h0000,  0, 0, 1, 16'h0005, 16'h00A9, 16'h00EE, 0);
    // write chained into read
    add(1, 1, 0, 16'h0000,  1, 0, 1, 16'h0005, 16'h00A9, 16'h00EE, 0);
    add(0, 0, 0, 16'h0000,  1, 1, 1, 16'h0005, 16'h00A9, 16'h00EE, 0);
    add(1, 0, 1, 16'h0000,  1, 0, 0, 16'h0006, 16'h00AA, 16'h00EE, 0);
    add(0, 0, 0, 16'h0000,  1, 1, 0, 16'h0006, 16'h00AA, 16'h00EE, 0);
    add(0, 0, 1, 16'h5A5A,  0, 0, 0, 16'h0007, 16'h00AA, 16'h5A5A, 1);
    add(0, 0, 0, 16'h0000,  0, 0, 0, 16'h0007, 16'h00AA, 16'h5A5A, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].t, vecs[i].w, vecs[i].r, vecs[i].pd);
      check_all($sformatf("vec%0d", i), vecs[i].psel, vecs[i].pen, vecs[i].pw,
                vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].rv);
    end

    // ---------------- asynchronous reset mid-ACCESS ----------------
    cycle(1, 1, 0, 16'h0000);   // SETUP
    cycle(0, 0, 0, 16'h0000);   // ACCESS, held by pready=0
    check("pre-reset penable", {31'd0, penable}, 32'd1);
    #2;
    rst = 1'b1;
    #1;                         // still well before the next rising edge
    check_all("async-reset", 0, 0, 0, 16'h0000, 16'h00A5, 16'h0000, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- counter wrap ----------------
    w_transfer = 1'b1; w_rd_wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_transfer = 1'b0;
    check("wrap setup pselect", {31'd0, w_pselect}, 32'd1);
    check("wrap setup paddr",   {16'd0, w_paddr},   32'h0000FFFF);
    check("wrap setup pwdata",  {16'd0, w_pwdata},  32'h0000FFFF);
    repeat (2) @(negedge clk);
    check("wrap done pselect", {31'd0, w_pselect},     32'd0);
    check("wrap done pwrite",  {31'd0, w_pwrite},      32'd1);
    check("wrap done paddr",   {16'd0, w_paddr},       32'h00000000);
    check("wrap done pwdata",  {16'd0, w_pwdata},      32'h00000000);
    check("wrap rdata",        {16'd0, w_rdata},       32'h00000000);
    check("wrap rdata_valid",  {31'd0, w_rdata_valid}, 32'd0);

    // ---------------- randomized run against the model ----------------
    model_reset();
    for (int i = 0; i < 500; i++) begin
      logic        t, w, r;
      logic [15:0] pd;
      t  = ($urandom_range(0, 9) < 6);
      w  = $urandom_range(0, 1) == 1;
      r  = ($urandom_range(0, 9) < 7);
      pd = 16'($urandom);
      transfer = t; rd_wr = w; pready = r; prdata = pd;
      @(posedge clk);
      model_edge(t, w, r, pd);
      @(negedge clk);
      check_all($sformatf("rand%0d", i), m_busy, m_busy && (m_age != 0), m_dir,
                m_addr, m_wd, m_rd, m_rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
